filt_cic_int: RTL
=================

# filt_cic_int

Cascaded integrator-comb interpolator, the transmit-side counterpart of the team's CIC decimator. It accepts one signed low-rate sample every `gp_interpolation_factor` enabled clocks and emits one signed high-rate sample per enabled clock. The input handshake is a pull strobe: the block tells the upstream source when it takes a sample. It sits between a low-rate sample source (NCO, FIR shaping filter) and a high-rate DAC or modulator path, and it runs on the same clock/enable scheme as the decimator.

## Interface
- `gp_interpolation_factor`, 4: rate change R; must be ≥ 2.
- `gp_order`, 3: number of comb stages and number of integrator stages (N).
- `gp_diff_delay`, 1: differential delay M of each comb stage.
- `gp_phase`, 0: ring-counter bit used as the low-rate strobe; must be < R.
- `gp_inp_width`, 8: input width.
- `gp_oup_width`, `gp_inp_width + gp_order*$clog2(gp_interpolation_factor*gp_diff_delay)`: internal and output width.
- `i_clk`, input, 1: clock.
- `i_rst_an`, input, 1: reset, asynchronous, active-low.
- `i_ena`, input, 1: high-rate clock enable. When low, all state freezes.
- `i_data`, input, `gp_inp_width`: signed low-rate sample. It is sampled only in a cycle where `o_req` = 1.
- `o_req`, output, 1: combinational pull strobe, equal to `r_count[gp_phase] & i_ena`.
- `o_data`, output, `gp_oup_width`: signed high-rate sample, registered.
- `o_vld`, output, 1: registered; high for one cycle after each edge that updated `o_data` with live data.

## Operation
- **Ring counter** (R bits, one-hot):
  - Reset value is all zero.
  - On the first enabled cycle with value zero, load bit 0.
  - After that, rotate left one bit per enabled cycle.
- **Comb section** (low rate, enable = `o_req`):
  - Sign-extend `i_data` to `gp_oup_width`.
  - Stage i: diff_i = in_i − in_i delayed by M strobes. The stages are chained combinationally.
  - Each delay line is a `shift_register` of M stages, enabled by `o_req`.
- **Upsampler:**
  - On `o_req`: `r_up` ← last comb difference, and `r_stuff` ← 1.
  - On any other enabled cycle: `r_stuff` ← 0.
  - Integrator input = `r_stuff ? r_up : 0`. This zero-stuffs R−1 zeros per sample.
- **Integrator section** (high rate, enable = `i_ena`):
  - Stage i: `w_int_add[i]` = input_i + `r_int_dly[i]`. The adds are chained combinationally.
  - Each `r_int_dly[i]` is a `dff` that captures `w_int_add[i]`.
  - `o_data` = `r_int_dly[N-1]`.
- **Valid tracking:**
  - `r_run` sets on the first enabled cycle with `r_stuff` = 1 and clears only on reset.
  - `o_vld` ← `i_ena & r_run`.
- **Arithmetic:** all adds and subtracts are two's complement and wrap modulo 2^`gp_oup_width`. There is no saturation; wrap-around is required for CIC correctness.
- **Gain:** DC gain is (R·M)^N / R. With the defaults this is 16, peaking at ±2032 for ±127, which fits the 14-bit output.
- **Reset values:** `o_data` = 0 and `o_vld` = 0. All integrator, comb, upsampler, `r_run` and counter registers are 0.

## Timing
- The first `o_req` occurs on enabled cycle 1 + `gp_phase` after reset release (enabled cycles counted from 0). After that it repeats every R enabled cycles.
- **Latency:** the sample captured at the `o_req` edge first affects `o_data` after the next enabled edge, i.e. it is visible two enabled edges after it is taken.
- **`i_ena` low:**
  - `o_req` = 0 and `o_vld` ← 0.
  - All registers hold, including the counter and `r_stuff`.
  - The high-rate sample stream resumes unchanged when `i_ena` returns.
- **Reset mid-operation:** all state clears immediately (asynchronous). The strobe phase restarts exactly as after power-up.
- **Simultaneous events:** `o_req` and integrator update share the same edge. The comb update and the integrator step read pre-edge values; there is no bypass.

## Structure
- Package `filt_cic_pkg`:
  - function `f_cic_width(inp_width, order, factor, diff_delay)`;
  - one-hot ring-counter width constant.
  
  The decimator also uses this package.
- Reuse the existing `dff` and `shift_register` blocks.
- Factor out sub-module `filt_cic_ring_cnt` (one-hot counter plus strobe select), shared with the decimator.

## Test plan
- **Impulse** (defaults): `i_data` = 1 at the first `o_req`, then 0.
  - Required: `o_data` = 1, 3, 6, 10, 12, 12, 10, 6, 3, 1 on consecutive enabled cycles, starting two enabled edges after capture, then 0.
  - Required: `o_vld` = 1 throughout.
- **DC step:** constant `i_data` = 5.
  - Required: `o_data` settles to 80 after (N+1)·R enabled cycles and stays there.
- **Negative full scale:** constant `i_data` = −128.
  - Required: settles to −2048 with no wrap error.
  - A ramp −128…127 matches a bit-exact reference model.
- **Enable gaps:** random `i_ena` duty of 30–100 %.
  - Required: the `o_data` sequence over enabled cycles is identical to the 100 % run.
  - Required: `o_req` and `o_vld` are never high while `i_ena` = 0.
- **Reset mid-stream** (during a step response):
  - Required: `o_data` = 0, `o_vld` = 0 and `o_req` = 0 immediately.
  - Required: the first `o_req` appears on enabled cycle 1 after release and the impulse response repeats exactly.
- **Parameter sweep:** `gp_phase` = 2, R = 2, M = 2, N = 1.
  - Required: the first `o_req` is on enabled cycle 3 for `gp_phase` = 2.
  - Required: the impulse response equals the coefficients of ((1−z^−RM)/(1−z^−1))^N for each setting.

Source files
------------

// File: rtl/filt_cic_pkg.sv
// Shared definitions for the CIC decimator/interpolator family.
//   f_cic_width  : internal/output width that makes the CIC arithmetic
//                  lossless under modulo wrap-around.
//   f_ring_width : width of the one-hot low-rate phase ring counter.
package filt_cic_pkg;

  // Ring width used when a counter is instantiated without an explicit width.
  localparam int unsigned lp_ring_width_dflt = 4;

  function automatic int f_cic_width(int inp_width, int order, int factor, int diff_delay);
    return inp_width + order * $clog2(factor * diff_delay);
  endfunction

  // One bit per high-rate phase within a low-rate period.
  function automatic int f_ring_width(int factor);
    return factor;
  endfunction

endpackage

// File: rtl/dff.sv
// Enabled D flip-flop bank with asynchronous active-low clear.
//   i_clk    : clock
//   i_rst_an : asynchronous reset, active-low (clears to 0)
//   i_ena    : capture enable
//   i_d      : data in
//   o_q      : registered data out
module dff #(
  parameter int unsigned gp_width = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_an,
  input  logic                i_ena,
  input  logic [gp_width-1:0] i_d,
  output logic [gp_width-1:0] o_q
);

  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      o_q <= '0;
    end else if (i_ena) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/filt_cic_ring_cnt.sv
// One-hot ring counter and low-rate strobe select for the CIC filters.
// The counter starts at zero, seeds bit 0 on its first enabled cycle and
// then rotates left once per enabled cycle; the strobe is the selected
// ring bit qualified by the enable.
//   i_clk    : clock
//   i_rst_an : asynchronous reset, active-low
//   i_ena    : high-rate clock enable
//   o_strobe : combinational low-rate strobe, r_count_q[gp_phase] & i_ena
module filt_cic_ring_cnt
  import filt_cic_pkg::*;
#(
  parameter int unsigned gp_width = lp_ring_width_dflt,
  parameter int unsigned gp_phase = 0
) (
  input  logic i_clk,
  input  logic i_rst_an,
  input  logic i_ena,
  output logic o_strobe
);

  localparam logic [gp_width-1:0] lp_seed = {{(gp_width-1){1'b0}}, 1'b1};

  logic [gp_width-1:0] r_count_q;
  logic [gp_width-1:0] r_count_d;

  always_comb begin
    r_count_d = r_count_q;
    if (i_ena) begin
      if (r_count_q == '0) begin
        r_count_d = lp_seed;
      end else begin
        r_count_d = {r_count_q[gp_width-2:0], r_count_q[gp_width-1]};
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      r_count_q <= '0;
    end else begin
      r_count_q <= r_count_d;
    end
  end

  assign o_strobe = r_count_q[gp_phase] & i_ena;

endmodule

// File: rtl/shift_register.sv
// Enabled delay line of gp_depth stages with asynchronous active-low clear.
//   i_clk    : clock
//   i_rst_an : asynchronous reset, active-low (clears every stage)
//   i_ena    : shift enable
//   i_d      : data into stage 0
//   o_q      : output of the last stage (i_d delayed by gp_depth enables)
module shift_register #(
  parameter int unsigned gp_width = 1,
  parameter int unsigned gp_depth = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_an,
  input  logic                i_ena,
  input  logic [gp_width-1:0] i_d,
  output logic [gp_width-1:0] o_q
);

  logic [gp_width-1:0] r_sr_q [gp_depth];

  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      for (int unsigned i = 0; i < gp_depth; i++) begin
        r_sr_q[i] <= '0;
      end
    end else if (i_ena) begin
      r_sr_q[0] <= i_d;
      for (int unsigned i = 1; i < gp_depth; i++) begin
        r_sr_q[i] <= r_sr_q[i-1];
      end
    end
  end

  assign o_q = r_sr_q[gp_depth-1];

endmodule

// File: rtl/filt_cic_int.sv
// CIC interpolator: N comb stages at the low rate, zero-stuffing upsampler,
// N integrator stages at the high rate. One sample is pulled from upstream
// (o_req) every gp_interpolation_factor enabled clocks; one output sample is
// produced per enabled clock. All arithmetic wraps modulo 2^gp_oup_width.
//   i_clk    : clock
//   i_rst_an : asynchronous reset, active-low
//   i_ena    : high-rate clock enable; all state holds while low
//   i_data   : signed low-rate sample, taken only when o_req = 1
//   o_req    : combinational pull strobe (ring bit gp_phase & i_ena)
//   o_data   : signed high-rate sample, registered
//   o_vld    : registered, high after each enabled edge carrying live data
module filt_cic_int
  import filt_cic_pkg::*;
#(
  parameter int gp_interpolation_factor = 4,
  parameter int gp_order                = 3,
  parameter int gp_diff_delay           = 1,
  parameter int gp_phase                = 0,
  parameter int gp_inp_width            = 8,
  parameter int gp_oup_width            = f_cic_width(gp_inp_width, gp_order,
                                                      gp_interpolation_factor, gp_diff_delay)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_an,
  input  logic                    i_ena,
  input  logic [gp_inp_width-1:0] i_data,
  output logic                    o_req,
  output logic [gp_oup_width-1:0] o_data,
  output logic                    o_vld
);

  localparam int          lp_w      = gp_oup_width;
  localparam int unsigned lp_n      = unsigned'(gp_order);
  localparam int unsigned lp_ring_w = unsigned'(f_ring_width(gp_interpolation_factor));

  // ---------------------------------------------------------------- strobe
  logic w_req;

  filt_cic_ring_cnt #(
    .gp_width (lp_ring_w),
    .gp_phase (unsigned'(gp_phase))
  ) u_ring_cnt (
    .i_clk    (i_clk),
    .i_rst_an (i_rst_an),
    .i_ena    (i_ena),
    .o_strobe (w_req)
  );

  assign o_req = w_req;

  // ------------------------------------------------------------ comb section
  logic [lp_w-1:0] w_comb_in  [lp_n];
  logic [lp_w-1:0] w_comb_dly [lp_n];
  logic [lp_w-1:0] w_comb_acc;

  // Running difference kept in one variable so the combinational stage
  // chain is a single ordered block rather than a self-referencing array.
  always_comb begin
    w_comb_acc = {{(lp_w-gp_inp_width){i_data[gp_inp_width-1]}}, i_data};
    for (int unsigned i = 0; i < lp_n; i++) begin
      w_comb_in[i] = w_comb_acc;
      w_comb_acc   = w_comb_acc - w_comb_dly[i];
    end
  end

  for (genvar g = 0; g < gp_order; g++) begin : g_comb
    shift_register #(
      .gp_width (lp_w),
      .gp_depth (unsigned'(gp_diff_delay))
    ) u_comb_dly (
      .i_clk    (i_clk),
      .i_rst_an (i_rst_an),
      .i_ena    (w_req),
      .i_d      (w_comb_in[g]),
      .o_q      (w_comb_dly[g])
    );
  end

  // --------------------------------------------------------------- upsampler
  logic [lp_w-1:0] r_up_q;
  logic [lp_w-1:0] r_up_d;
  logic            r_stuff_q;
  logic            r_stuff_d;

  always_comb begin
    r_up_d    = r_up_q;
    r_stuff_d = r_stuff_q;
    if (w_req) begin
      r_up_d    = w_comb_acc;
      r_stuff_d = 1'b1;
    end else if (i_ena) begin
      r_stuff_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      r_up_q    <= '0;
      r_stuff_q <= 1'b0;
    end else begin
      r_up_q    <= r_up_d;
      r_stuff_q <= r_stuff_d;
    end
  end

  // ------------------------------------------------------ integrator section
  logic [lp_w-1:0] w_int_add [lp_n];
  logic [lp_w-1:0] r_int_dly [lp_n];
  logic [lp_w-1:0] w_int_acc;

  // Each stage adds its own state to the previous stage's sum in the same
  // cycle; the accumulator variable carries the chain.
  always_comb begin
    w_int_acc = r_stuff_q ? r_up_q : '0;
    for (int unsigned i = 0; i < lp_n; i++) begin
      w_int_acc    = w_int_acc + r_int_dly[i];
      w_int_add[i] = w_int_acc;
    end
  end

  for (genvar g = 0; g < gp_order; g++) begin : g_int
    dff #(
      .gp_width (lp_w)
    ) u_int_dly (
      .i_clk    (i_clk),
      .i_rst_an (i_rst_an),
      .i_ena    (i_ena),
      .i_d      (w_int_add[g]),
      .o_q      (r_int_dly[g])
    );
  end

  assign o_data = r_int_dly[lp_n-1];

  // ---------------------------------------------------------- valid tracking
  logic r_run_q;
  logic r_run_d;
  logic r_vld_q;
  logic r_vld_d;

  // Valid follows the next-state run flag, so the edge that first
  // integrates a stuffed sample already reports its output as valid.
  always_comb begin
    r_run_d = r_run_q | (i_ena & r_stuff_q);
    r_vld_d = i_ena & r_run_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      r_run_q <= 1'b0;
      r_vld_q <= 1'b0;
    end else begin
      r_run_q <= r_run_d;
      r_vld_q <= r_vld_d;
    end
  end

  assign o_vld = r_vld_q;

endmodule
